// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for IF fetch and MEM load/store
// Data access wins over fetch; each access runs BUSY -> ack -> DONE with one-cycle ready pulses.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              stall_if,
  output logic              stall_d,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic                flushed_q, flushed_d;
  logic                ram_req_q, ram_req_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                d_ready_q, d_ready_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flushed_q   <= 1'b0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flushed_q   <= flushed_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flushed_d   = flushed_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_read | d_write) begin
          state_d     = D_BUSY;
          ram_req_d   = 1'b1;
          ram_we_d    = d_write;
          ram_addr_d  = d_addr;
          ram_wdata_d = d_wdata;
        end else if (if_req & ~if_flush) begin
          state_d     = IF_BUSY;
          ram_req_d   = 1'b1;
          ram_we_d    = 1'b0;
          ram_addr_d  = if_addr;
          ram_wdata_d = '0;
        end
      end
      IF_BUSY: begin
        if (if_flush) flushed_d = 1'b1;
        if (ram_ack) begin
          ram_req_d = 1'b0;
          state_d   = DONE;
          // A flush seen in the ack cycle itself must also suppress the result.
          if (!(flushed_q | if_flush)) begin
            if_rdata_d = ram_rdata;
            if_ready_d = 1'b1;
          end
        end
      end
      D_BUSY: begin
        if (ram_ack) begin
          ram_req_d = 1'b0;
          state_d   = DONE;
          d_ready_d = 1'b1;
          if (!ram_we_q) d_rdata_d = ram_rdata;
        end
      end
      DONE: begin
        state_d   = IDLE;
        flushed_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign stall_if  = if_req & ~if_ready_q & ~if_flush;
  assign stall_d   = (d_read | d_write) & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Transaction-level expectations: data before fetch, ready one cycle after ack, flush suppresses fetch result.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, d_read, d_write, ram_ack;
  logic [31:0] if_addr, d_addr, d_wdata, ram_rdata;
  logic [31:0] if_rdata, d_rdata, ram_addr, ram_wdata;
  logic        if_ready, d_ready, stall_if, stall_d, ram_req, ram_we;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_if_rdata, exp_d_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .stall_if(stall_if), .stall_d(stall_d),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One memory access from the IDLE decision edge through DONE and back to IDLE.
  task automatic serve(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input int lat, input int fl,
                       input logic [31:0] rd);
    bit flushed = 1'b0;
    bit exp_ifr;
    @(posedge clk); #1;
    chkb("req_rise", ram_req, 1'b1);
    chk("req_addr", ram_addr, addr);
    chkb("req_we", ram_we, we);
    if (we) chk("req_wdata", ram_wdata, wd);
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) begin
        chkb("req_hold", ram_req, 1'b1);
        chk("addr_hold", ram_addr, addr);
        chkb("we_hold", ram_we, we);
        if (we) chk("wdata_hold", ram_wdata, wd);
      end
      chkb("if_ready_busy", if_ready, 1'b0);
      chkb("d_ready_busy", d_ready, 1'b0);
      if (fl == c) begin
        if_flush = 1'b1;
        flushed  = 1'b1;
      end
      if (c == lat) begin
        ram_ack   = 1'b1;
        ram_rdata = rd;
      end
      #1;
      chkb("stall_d_busy", stall_d, is_d);
      chkb("stall_if_busy", stall_if, if_req & ~if_flush);
      @(posedge clk); #1;
      ram_ack  = 1'b0;
      if_flush = 1'b0;
      ram_rdata = $urandom;
      #1;
    end
    chkb("req_clear", ram_req, 1'b0);
    if (is_d) begin
      exp_ifr = 1'b0;
      chkb("d_ready", d_ready, 1'b1);
      chkb("if_ready_quiet", if_ready, 1'b0);
      if (!we) exp_d_rdata = rd;
      chk("d_rdata", d_rdata, exp_d_rdata);
      chkb("stall_d_done", stall_d, 1'b0);
    end else begin
      exp_ifr = !flushed;
      chkb("if_ready", if_ready, exp_ifr);
      chkb("d_ready_quiet", d_ready, 1'b0);
      if (!flushed) exp_if_rdata = rd;
      chk("if_rdata", if_rdata, exp_if_rdata);
    end
    chkb("stall_if_done", stall_if, if_req & ~exp_ifr);
    @(posedge clk); #1;
    chkb("no_reissue", ram_req, 1'b0);
    chkb("if_ready_drop", if_ready, 1'b0);
    chkb("d_ready_drop", d_ready, 1'b0);
    if (is_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      if_req = 1'b0;
    end
  endtask

  // dop: 0 none, 1 load, 2 store. Called in an IDLE cycle.
  task automatic group(input int dop, input bit fe, input logic [31:0] da, input logic [31:0] fa,
                       input logic [31:0] wd, input int ld, input int lf, input int fld,
                       input int flf, input logic [31:0] rdd, input logic [31:0] rdf);
    d_read  = (dop == 1);
    d_write = (dop == 2);
    d_addr  = da;
    d_wdata = wd;
    if_req  = fe;
    if_addr = fa;
    #1;
    chkb("stall_d_idle", stall_d, dop != 0);
    chkb("stall_if_idle", stall_if, fe);
    if (dop != 0) serve(1'b1, dop == 2, da, wd, ld, fld, rdd);
    if (fe) serve(1'b0, 1'b0, fa, 32'h0, lf, flf, rdf);
  endtask

  initial begin
    int dop, ld, lf, fld, flf;
    bit fe;
    rst_n = 1'b0;
    if_req = 1'b0; if_flush = 1'b0; d_read = 1'b0; d_write = 1'b0; ram_ack = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; ram_rdata = '0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    #2;
    chkb("rst_ram_req", ram_req, 1'b0);
    chkb("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chkb("rst_if_ready", if_ready, 1'b0);
    chkb("rst_d_ready", d_ready, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    #1;
    rst_n = 1'b1;

    group(0, 1'b1, 32'h0, 32'h100, 32'h0, 1, 1, 0, 0, 32'h0, 32'h2402000A);
    group(1, 1'b1, 32'h40, 32'h104, $urandom, 3, 3, 0, 0, $urandom, $urandom);
    group(2, 1'b0, 32'h80, 32'h0, 32'hDEADBEEF, 2, 1, 0, 0, $urandom, 32'h0);
    group(0, 1'b1, 32'h0, 32'h1F0, 32'h0, 3, 3, 0, 2, 32'h0, 32'hBAD0BAD0);
    group(0, 1'b1, 32'h0, 32'h200, 32'h0, 2, 2, 0, 0, 32'h0, 32'h8C220004);
    group(0, 1'b1, 32'h0, 32'h204, 32'h0, 2, 2, 0, 2, 32'h0, 32'h11111111);

    if_req = 1'b1; if_addr = 32'h300; if_flush = 1'b1;
    #1;
    chkb("stall_if_flush_idle", stall_if, 1'b0);
    @(posedge clk); #1;
    chkb("flush_blocks_start", ram_req, 1'b0);
    if_req = 1'b0; if_flush = 1'b0;

    ram_ack = 1'b1; ram_rdata = 32'hFFFF0000;
    @(posedge clk); #1;
    ram_ack = 1'b0;
    chkb("idle_ack_req", ram_req, 1'b0);
    chkb("idle_ack_if_ready", if_ready, 1'b0);
    chkb("idle_ack_d_ready", d_ready, 1'b0);
    chk("idle_ack_if_rdata", if_rdata, exp_if_rdata);
    chk("idle_ack_d_rdata", d_rdata, exp_d_rdata);

    for (int i = 0; i < 150; i++) begin
      dop = $urandom_range(0, 2);
      fe  = $urandom_range(0, 1);
      if (dop == 0) fe = 1'b1;
      ld  = $urandom_range(1, 4);
      lf  = $urandom_range(1, 4);
      fld = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ld) : 0;
      flf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lf) : 0;
      group(dop, fe, $urandom, $urandom, $urandom, ld, lf, fld, flf, $urandom, $urandom);
    end

    group(1, 1'b1, 32'h44, 32'h108, 32'h0, 1, 1, 0, 0, 32'h12345678, 32'h9ABCDEF0);
    d_read = 1'b1; d_addr = 32'h48;
    @(posedge clk); #1;
    chkb("pre_reset_req", ram_req, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chkb("async_rst_req", ram_req, 1'b0);
    chkb("async_rst_if_ready", if_ready, 1'b0);
    chkb("async_rst_d_ready", d_ready, 1'b0);
    chk("async_rst_if_rdata", if_rdata, 32'h0);
    chk("async_rst_d_rdata", d_rdata, 32'h0);
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    rst_n = 1'b1;
    group(1, 1'b0, 32'h48, 32'h0, 32'h0, 2, 1, 0, 0, 32'hCAFEF00D, 32'h0);
    group(0, 1'b1, 32'h0, 32'h10C, 32'h0, 1, 1, 0, 0, 32'h0, 32'h0BADCAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
